// File: rtl/rc4_stream_xor.sv
// rtl/rc4_stream_xor.sv - RC4 keystream capture FIFO with optional drop[n] and 1:1 byte XOR stream
module rc4_stream_xor #(
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_N     = 0,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync_clr,
    input  logic                          ks_valid,
    input  logic [7:0]                    ks_byte,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [7:0]                    din_data,
    input  logic                          din_last,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [7:0]                    dout_data,
    output logic                          dout_last,
    output logic [$clog2(FIFO_DEPTH):0]   ks_level,
    output logic                          ks_overflow,
    output logic [CNT_W-1:0]              byte_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
    localparam logic [DW-1:0] DROP_LAST = DW'((DROP_N > 0) ? DROP_N - 1 : 0);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_DROP,
        S_RUN
    } state_t;

    localparam state_t START_STATE = (DROP_N == 0) ? S_RUN : S_DROP;

    state_t          state;
    logic            ks_prev;
    logic [DW-1:0]   drop_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            take;
    logic            full;
    logic            pop;
    logic            push;

    // The generator strobe may be a level; only its rising edge carries a new byte.
    assign take      = ks_valid & ~ks_prev;
    assign full      = (ks_level == FULL_LVL);
    assign din_ready = ~sync_clr & (state == S_RUN) & (ks_level != '0)
                       & (~dout_valid | dout_ready);
    assign pop       = din_valid & din_ready;
    assign push      = take & ~sync_clr & (state == S_RUN) & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ks_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= START_STATE;
            ks_prev     <= 1'b0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ks_level    <= '0;
            dout_valid  <= 1'b0;
            dout_data   <= 8'h00;
            dout_last   <= 1'b0;
            ks_overflow <= 1'b0;
            byte_count  <= '0;
        end else begin
            ks_prev <= ks_valid;
            if (sync_clr) begin
                state       <= START_STATE;
                drop_cnt    <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                ks_level    <= '0;
                dout_valid  <= 1'b0;
                ks_overflow <= 1'b0;
                byte_count  <= '0;
            end else begin
                if (take && state == S_DROP) begin
                    drop_cnt <= drop_cnt + DW'(1);
                    if (drop_cnt == DROP_LAST) begin
                        state <= S_RUN;
                    end
                end
                // A same-cycle pop frees the slot, so only an unmatched push into a full FIFO is lost.
                if (take && state == S_RUN && full && !pop) begin
                    ks_overflow <= 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                ks_level <= ks_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
                if (pop) begin
                    dout_data  <= din_data ^ mem[rd_ptr];
                    dout_last  <= din_last;
                    dout_valid <= 1'b1;
                    byte_count <= byte_count + CNT_W'(1);
                end else if (dout_valid && dout_ready) begin
                    dout_valid <= 1'b0;
                end
            end
        end
    end

endmodule
